square_add: RTL and testbench

- Inverse of the sqrt unit. Reconstructs the radicand as D = Q*Q + remainder using an iterative shift-add squarer.
- Compares the result against an expected radicand.
- Sits beside the sqrt datapath as the hardware round-trip checker: sqrt outputs in, reconstructed D and a match flag out.
- Start/ready handshake with the same feel as sqrt: one multiplier bit per clock.

---
 rtl/sqrt_pkg.sv | 6 +
 rtl/square_add.sv | 90 +++++++++
 tb/tb_square_add.sv | 117 +++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared constants and state type for the sqrt datapath and its round-trip checker.
package sqrt_pkg;
  localparam int DW_DEFAULT = 16;
  localparam int CW = $clog2(DW_DEFAULT) + 1;
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} sq_state_t;
endpackage

// File: rtl/square_add.sv
// square_add: rebuilds D = Q*Q + remainder with a one-bit-per-clock shift-add squarer and flags D == D_expected.
module square_add
  import sqrt_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DW-1:0]         Q,
  input  logic [DW-1:0]         remainder,
  input  logic [2*DW-1:0]       D_expected,
  output logic [2*DW-1:0]       D,
  output logic                  match,
  output logic                  busy,
  output logic                  ready,
  output logic [$clog2(DW):0]   excounter
);
  localparam int LCW = $clog2(DW) + 1;
  sq_state_t         state_q, state_d;
  logic [DW-1:0]     mcand_q, mcand_d, mult_q, mult_d, rem_q, rem_d;
  logic [2*DW-1:0]   dexp_q, dexp_d, acc_q, acc_d, d_q, d_d, sum;
  logic [LCW-1:0]    cnt_q, cnt_d, sh;
  logic              match_q, match_d;
  assign sh  = LCW'(DW) - cnt_q;
  assign sum = acc_q + {{DW{1'b0}}, rem_q};
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    rem_d   = rem_q;
    dexp_d  = dexp_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    match_d = match_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d = Q;
        mult_d  = Q;
        rem_d   = remainder;
        dexp_d  = D_expected;
        acc_d   = '0;
        cnt_d   = LCW'(DW);
        state_d = MUL;
      end
      MUL: begin
        // partial product weight grows by one bit each step, LSB of multiplier first
        acc_d   = acc_q + (mult_q[0] ? ({{DW{1'b0}}, mcand_q} << sh) : '0);
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q - LCW'(1);
        state_d = (cnt_q == LCW'(1)) ? ADD : MUL;
      end
      ADD: begin
        d_d     = sum;
        match_d = (sum == dexp_q);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      rem_q   <= '0;
      dexp_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      rem_q   <= rem_d;
      dexp_q  <= dexp_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      match_q <= match_d;
    end
  end
  assign D         = d_q;
  assign match     = match_q;
  assign busy      = (state_q == MUL) || (state_q == ADD);
  assign ready     = (state_q == DONE);
  assign excounter = cnt_q;
endmodule

// File: tb/tb_square_add.sv
// tb_square_add: randomized round-trip checks of square_add against an arithmetic Q*Q+remainder model.
module tb_square_add;
  localparam int DW = 16;
  logic            clk = 1'b0;
  logic            reset, start;
  logic [DW-1:0]   Q, remainder;
  logic [2*DW-1:0] D_expected, D;
  logic            match, busy, ready;
  logic [$clog2(DW):0] excounter;
  int checks = 0;
  int errors = 0;

  square_add #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .Q(Q), .remainder(remainder),
    .D_expected(D_expected), .D(D), .match(match), .busy(busy), .ready(ready),
    .excounter(excounter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // hold keeps start asserted, with changing operands, for the whole run
  task automatic run_op(input logic [DW-1:0] q, input logic [DW-1:0] r,
                        input logic [2*DW-1:0] dx, input bit hold);
    logic [2*DW-1:0] e;
    int n, walk_bad, busy_bad;
    e = (2*DW)'(q) * (2*DW)'(q) + (2*DW)'(r);
    @(negedge clk);
    Q = q; remainder = r; D_expected = dx; start = 1'b1;
    @(negedge clk);
    start = hold;
    n = 1; walk_bad = 0; busy_bad = 0;
    while (!ready && n < 64) begin
      if (int'(excounter) != ((n <= DW + 1) ? DW - n + 1 : 0)) walk_bad++;
      if (!busy) busy_bad++;
      Q = DW'($urandom); remainder = DW'($urandom); D_expected = $urandom;
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n + 1), 64'(DW + 3));
    chk("busy_run", 64'(busy_bad), 0);
    chk("excounter_walk", 64'(walk_bad), 0);
    chk("busy_at_ready", 64'(busy), 0);
    chk("D", 64'(D), 64'(e));
    chk("match", 64'(match), 64'(e == dx));
    start = 1'b0;
    @(negedge clk);
    chk("ready_once", 64'(ready), 0);
    chk("idle_after", 64'(busy), 0);
    chk("D_hold", 64'(D), 64'(e));
    chk("match_hold", 64'(match), 64'(e == dx));
  endtask

  initial begin
    logic [DW-1:0] q, r;
    logic [2*DW-1:0] e;
    int n, pulses;
    reset = 1'b1; start = 1'b0; Q = '0; remainder = '0; D_expected = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_D", 64'(D), 0);
    chk("rst_match", 64'(match), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(ready), 0);
    chk("rst_excounter", 64'(excounter), 0);

    run_op(16'd11, 16'd6, 32'd127, 1'b0);
    run_op(16'd11, 16'd6, 32'd128, 1'b0);
    run_op(16'd0, 16'd0, 32'd0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFF0000, 1'b0);
    run_op(16'd3, 16'd4, 32'd13, 1'b1);

    // reset partway through MUL must abort without a ready pulse
    @(negedge clk);
    Q = 16'd11; remainder = 16'd6; D_expected = 32'd127; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (excounter != 5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_cnt5", 64'(excounter), 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_D", 64'(D), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_ready", 64'(ready), 0);
    chk("abort_excounter", 64'(excounter), 0);
    pulses = 0;
    repeat (DW + 4) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("abort_no_ready", 64'(pulses), 0);
    run_op(16'd11, 16'd6, 32'd127, 1'b0);

    repeat (20) begin
      q = DW'($urandom);
      r = DW'($urandom);
      e = (2*DW)'(q) * (2*DW)'(q) + (2*DW)'(r);
      run_op(q, r, ($urandom_range(0, 1) == 0) ? e : e ^ (32'd1 << $urandom_range(0, 31)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
